control_unit: RTL and testbench

//  Sequencer that sits directly upstream of the datapath and drives its control inputs.

---
 rtl/control_unit.sv | 147 ++++++++++++++
 tb/tb_control_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Instruction sequencer: fetches from a 1-cycle-latency ROM, decodes, and drives the
// datapath control/immediate ports for one EXEC cycle per instruction.
module control_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic [7:0]         r15_in,
  output logic               writeEnable,
  output logic               writeSourceSelect,
  output logic               muxASelect,
  output logic               muxBSelect,
  output logic [7:0]         extInputData,
  output logic [3:0]         destAddress,
  output logic [3:0]         aAddress,
  output logic [3:0]         bAddress,
  output logic [3:0]         aluOpCode,
  output logic               busy,
  output logic               halted,
  output logic               illegal_op
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StWait, StHalt} stateT;

  localparam logic [3:0] ClsNop   = 4'd0;
  localparam logic [3:0] ClsAluRR = 4'd1;
  localparam logic [3:0] ClsAluRI = 4'd2;
  localparam logic [3:0] ClsAluIR = 4'd3;
  localparam logic [3:0] ClsLoadI = 4'd4;
  localparam logic [3:0] ClsJmp   = 4'd5;
  localparam logic [3:0] ClsJz15  = 4'd6;
  localparam logic [3:0] ClsWait  = 4'd7;
  localparam logic [3:0] ClsHalt  = 4'd8;

  stateT             state;
  logic [PC_W-1:0]   pc;
  logic [INSTR_W-1:0] ir;
  logic [7:0]        waitCnt;
  logic              illegalOp;

  logic [3:0]      irClass, irOp, irDest, irA, irB;
  logic [7:0]      irImm;
  logic [PC_W-1:0] pcInc, immPc;

  assign irClass = ir[27:24];
  assign irOp    = ir[23:20];
  assign irDest  = ir[19:16];
  assign irA     = ir[15:12];
  assign irB     = ir[11:8];
  assign irImm   = ir[7:0];
  assign pcInc   = pc + PC_W'(1);
  // Jump targets are truncated (or zero-extended) to the PC width.
  assign immPc   = PC_W'(irImm);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      pc        <= '0;
      ir        <= '0;
      waitCnt   <= '0;
      illegalOp <= 1'b0;
    end else begin
      case (state)
        StIdle, StHalt: begin
          if (start) begin
            pc    <= '0;
            state <= StFetch;
          end
        end
        StFetch:  state <= StDecode;
        StDecode: begin
          ir    <= instr_data;
          state <= StExec;
        end
        StExec: begin
          state <= StFetch;
          pc    <= pcInc;
          case (irClass)
            ClsNop, ClsAluRR, ClsAluRI, ClsAluIR, ClsLoadI: ;
            ClsJmp:  pc <= immPc;
            ClsJz15: if (r15_in == 8'd0) pc <= immPc;
            ClsWait: begin
              if (irImm != 8'd0) begin
                state   <= StWait;
                waitCnt <= irImm;
              end
            end
            ClsHalt: state <= StHalt;
            default: illegalOp <= 1'b1;
          endcase
        end
        StWait: begin
          waitCnt <= waitCnt - 8'd1;
          if (waitCnt <= 8'd1) state <= StFetch;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Controls derive only from registered state/IR, so they are glitch-free single-cycle pulses.
  always_comb begin
    writeEnable       = 1'b0;
    writeSourceSelect = 1'b0;
    muxASelect        = 1'b0;
    muxBSelect        = 1'b0;
    extInputData      = 8'd0;
    destAddress       = 4'd0;
    aAddress          = 4'd0;
    bAddress          = 4'd0;
    aluOpCode         = 4'd0;
    if (state == StExec) begin
      extInputData = irImm;
      destAddress  = irDest;
      aAddress     = irA;
      bAddress     = irB;
      aluOpCode    = irOp;
      case (irClass)
        ClsAluRR: writeEnable = 1'b1;
        ClsAluRI: begin
          writeEnable = 1'b1;
          muxBSelect  = 1'b1;
        end
        ClsAluIR: begin
          writeEnable = 1'b1;
          muxASelect  = 1'b1;
        end
        ClsLoadI: begin
          writeEnable       = 1'b1;
          writeSourceSelect = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instr_addr = pc;
  assign busy       = (state == StFetch) || (state == StDecode) || (state == StExec) ||
                      (state == StWait);
  assign halted     = (state == StHalt);
  assign illegal_op = illegalOp;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a synchronous ROM model feeds programs, outputs are
// sampled on the falling edge and compared against hand-computed values.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  instr_addr;
  logic [27:0] instr_data;
  logic [7:0]  r15_in;
  logic        writeEnable, writeSourceSelect, muxASelect, muxBSelect;
  logic [7:0]  extInputData;
  logic [3:0]  destAddress, aAddress, bAddress, aluOpCode;
  logic        busy, halted, illegal_op;

  logic [27:0] rom [256];
  int total = 0;
  int bad   = 0;

  control_unit #(.PC_W(8), .INSTR_W(28)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .instr_addr        (instr_addr),
    .instr_data        (instr_data),
    .r15_in            (r15_in),
    .writeEnable       (writeEnable),
    .writeSourceSelect (writeSourceSelect),
    .muxASelect        (muxASelect),
    .muxBSelect        (muxBSelect),
    .extInputData      (extInputData),
    .destAddress       (destAddress),
    .aAddress          (aAddress),
    .bAddress          (bAddress),
    .aluOpCode         (aluOpCode),
    .busy              (busy),
    .halted            (halted),
    .illegal_op        (illegal_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_data <= rom[instr_addr];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk(input logic [3:0] c, input logic [3:0] op,
                                     input logic [3:0] d, input logic [3:0] a,
                                     input logic [3:0] b, input logic [7:0] imm);
    return {c, op, d, a, b, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 28'd0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Pulse start from IDLE/HALT and stop on the EXEC cycle of the first instruction.
  task automatic runToExec();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    r15_in = 8'd0;
    clearRom();

    // LOADI d=15 imm=5A
    rom[0] = mk(4'h4, 4'h0, 4'hF, 4'h0, 4'h0, 8'h5A);
    resetDut();
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    checkVal("rst_halted", {31'd0, halted}, 32'd0);
    checkVal("rst_we", {31'd0, writeEnable}, 32'd0);
    checkVal("rst_addr", {24'd0, instr_addr}, 32'd0);
    checkVal("rst_illegal", {31'd0, illegal_op}, 32'd0);
    runToExec();
    checkVal("ldi_we", {31'd0, writeEnable}, 32'd1);
    checkVal("ldi_wss", {31'd0, writeSourceSelect}, 32'd1);
    checkVal("ldi_dest", {28'd0, destAddress}, 32'hF);
    checkVal("ldi_imm", {24'd0, extInputData}, 32'h5A);
    checkVal("ldi_busy", {31'd0, busy}, 32'd1);
    tick(1);
    checkVal("ldi_we_after", {31'd0, writeEnable}, 32'd0);
    checkVal("ldi_imm_after", {24'd0, extInputData}, 32'd0);
    checkVal("ldi_dest_after", {28'd0, destAddress}, 32'd0);
    checkVal("ldi_pc", {24'd0, instr_addr}, 32'd1);

    // ALU_RI op=3 d=2 a=1 imm=07
    rom[0] = mk(4'h2, 4'h3, 4'h2, 4'h1, 4'h0, 8'h07);
    resetDut();
    runToExec();
    checkVal("ri_muxb", {31'd0, muxBSelect}, 32'd1);
    checkVal("ri_muxa", {31'd0, muxASelect}, 32'd0);
    checkVal("ri_op", {28'd0, aluOpCode}, 32'd3);
    checkVal("ri_a", {28'd0, aAddress}, 32'd1);
    checkVal("ri_dest", {28'd0, destAddress}, 32'd2);
    checkVal("ri_we", {31'd0, writeEnable}, 32'd1);
    checkVal("ri_wss", {31'd0, writeSourceSelect}, 32'd0);
    tick(1);
    checkVal("ri_pc", {24'd0, instr_addr}, 32'd1);

    // JZ15 imm=10, taken then not taken
    rom[0] = mk(4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 8'h10);
    r15_in = 8'h00;
    resetDut();
    runToExec();
    checkVal("jz_we", {31'd0, writeEnable}, 32'd0);
    tick(1);
    checkVal("jz_taken", {24'd0, instr_addr}, 32'h10);
    r15_in = 8'h01;
    resetDut();
    runToExec();
    tick(1);
    checkVal("jz_not_taken", {24'd0, instr_addr}, 32'h01);
    r15_in = 8'h00;

    // WAIT 4, WAIT 0 (dest=9 marks its EXEC), LOADI d=1 imm=33
    clearRom();
    rom[0] = mk(4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 8'd4);
    rom[1] = mk(4'h7, 4'h0, 4'h9, 4'h0, 4'h0, 8'd0);
    rom[2] = mk(4'h4, 4'h0, 4'h1, 4'h0, 4'h0, 8'h33);
    resetDut();
    runToExec();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) start = 1'b1;  // must be ignored while busy
      tick(1);
      start = 1'b0;
      checkVal($sformatf("wait_busy%0d", i), {31'd0, busy}, 32'd1);
      checkVal($sformatf("wait_we%0d", i), {31'd0, writeEnable}, 32'd0);
      checkVal($sformatf("wait_pc%0d", i), {24'd0, instr_addr}, 32'd1);
    end
    tick(3);
    checkVal("wait0_exec_dest", {28'd0, destAddress}, 32'd9);
    tick(1);
    checkVal("wait0_fetch_pc", {24'd0, instr_addr}, 32'd2);
    tick(2);
    checkVal("after_wait_we", {31'd0, writeEnable}, 32'd1);
    checkVal("after_wait_imm", {24'd0, extInputData}, 32'h33);

    // JMP FF, NOP at FF wraps PC to 0
    clearRom();
    rom[0] = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 8'hFF);
    resetDut();
    runToExec();
    tick(1);
    checkVal("jmp_target", {24'd0, instr_addr}, 32'hFF);
    tick(3);
    checkVal("pc_wrap", {24'd0, instr_addr}, 32'h00);

    // Illegal class C: executes as NOP, illegal_op sticky until rst
    clearRom();
    rom[0] = mk(4'hC, 4'h5, 4'h3, 4'h2, 4'h1, 8'hAA);
    resetDut();
    runToExec();
    checkVal("ill_we", {31'd0, writeEnable}, 32'd0);
    tick(1);
    checkVal("ill_set", {31'd0, illegal_op}, 32'd1);
    checkVal("ill_pc", {24'd0, instr_addr}, 32'd1);
    tick(6);
    checkVal("ill_held", {31'd0, illegal_op}, 32'd1);
    resetDut();
    checkVal("ill_cleared", {31'd0, illegal_op}, 32'd0);

    // HALT, then restart from PC 0
    clearRom();
    rom[0] = mk(4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    rom[1] = mk(4'h4, 4'h0, 4'h1, 4'h0, 4'h0, 8'h11);
    resetDut();
    runToExec();
    tick(1);
    checkVal("halt_halted", {31'd0, halted}, 32'd1);
    checkVal("halt_busy", {31'd0, busy}, 32'd0);
    checkVal("halt_we", {31'd0, writeEnable}, 32'd0);
    checkVal("halt_pc", {24'd0, instr_addr}, 32'd1);
    tick(2);
    checkVal("halt_stays", {31'd0, halted}, 32'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkVal("restart_pc", {24'd0, instr_addr}, 32'd0);
    checkVal("restart_busy", {31'd0, busy}, 32'd1);
    checkVal("restart_halted", {31'd0, halted}, 32'd0);

    // rst mid-WAIT
    clearRom();
    rom[0] = mk(4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 8'd10);
    resetDut();
    runToExec();
    tick(2);
    checkVal("midwait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkVal("midwait_rst_busy", {31'd0, busy}, 32'd0);
    checkVal("midwait_rst_pc", {24'd0, instr_addr}, 32'd0);
    checkVal("midwait_rst_halted", {31'd0, halted}, 32'd0);
    tick(3);
    checkVal("midwait_idle_stays", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
